// File: rtl/irsx_register_emulator.sv
// Purpose: responder side of the IRSX slow-control serial port (sin/sclk/pclk/regclr/shout) with a 256x12 register file.
// Latency: SYNC_STAGES+1 clocks from an input edge to its effect; host_data is one clock after host_address.
// Backpressure: none; the master must hold each sclk/pclk level for at least SYNC_STAGES+2 clocks.
module irsx_register_emulator #(
   parameter int SYNC_STAGES            = 2,
   parameter int NUMBER_OF_ADDRESS_BITS = 8,
   parameter int NUMBER_OF_DATA_BITS    = 12
) (
   input  logic                                                clock,
   input  logic                                                reset,
   input  logic                                                sin,
   input  logic                                                sclk,
   input  logic                                                pclk,
   input  logic                                                regclr,
   output logic                                                shout,
   input  logic [NUMBER_OF_ADDRESS_BITS-1:0]                   host_address,
   output logic [NUMBER_OF_DATA_BITS-1:0]                      host_data,
   output logic                                                clearing,
   output logic [NUMBER_OF_ADDRESS_BITS+NUMBER_OF_DATA_BITS-1:0] latched_word,
   output logic [31:0]                                         number_of_loads,
   output logic [31:0]                                         number_of_framing_errors
);

   localparam int WORD_BITS = NUMBER_OF_ADDRESS_BITS + NUMBER_OF_DATA_BITS;
   localparam int DEPTH     = 2 ** NUMBER_OF_ADDRESS_BITS;
   localparam logic [4:0] FULL_COUNT = 5'(WORD_BITS);
   localparam logic [4:0] MAX_COUNT  = 5'd31;
   localparam logic [NUMBER_OF_ADDRESS_BITS-1:0] LAST_ADDRESS = '1;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // ---------------------------------------------------------------------
   // Input synchronizers and edge detection
   // ---------------------------------------------------------------------
   logic [3:0] raw_in;
   logic [3:0] sync_out;
   logic [2:0] sync_prev;

   assign raw_in = {sin, sclk, pclk, regclr};

   generate
      if (SYNC_STAGES == 0) begin : g_no_sync
         assign sync_out = raw_in;
      end else begin : g_sync
         logic [3:0] stage [SYNC_STAGES];
         // Synchronizer chain runs free through reset so the edge detector
         // tracks the real line levels and sees no false edge at release.
         always_ff @(posedge clock) begin
            stage[0] <= raw_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
               stage[i] <= stage[i-1];
            end
         end
         assign sync_out = stage[SYNC_STAGES-1];
      end
   endgenerate

   // Previous synchronized level of sclk/pclk/regclr, for single-cycle edge pulses
   always_ff @(posedge clock) begin
      sync_prev <= sync_out[2:0];
   end

   logic sin_s;
   logic sclk_rise;
   logic sclk_fall;
   logic pclk_rise;
   logic regclr_rise;

   assign sin_s       = sync_out[3];
   assign sclk_rise   =  sync_out[2] & ~sync_prev[2];
   assign sclk_fall   = ~sync_out[2] &  sync_prev[2];
   assign pclk_rise   =  sync_out[1] & ~sync_prev[1];
   assign regclr_rise =  sync_out[0] & ~sync_prev[0];

   // ---------------------------------------------------------------------
   // Clear sweep state machine
   // ---------------------------------------------------------------------
   state_t                            state;
   state_t                            state_next;
   logic [NUMBER_OF_ADDRESS_BITS-1:0] clear_addr;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_CLEAR;
      end else begin
         state <= state_next;
      end
   end

   // Next state: sweep to the last address, restart on every regclr rise
   always_comb begin
      state_next = state;
      case (state)
         ST_CLEAR: begin
            if (!regclr_rise && clear_addr == LAST_ADDRESS) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (regclr_rise) begin
               state_next = ST_CLEAR;
            end
         end
         default: state_next = ST_CLEAR;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      clearing = (state == ST_CLEAR);
   end

   // Sweep address: one register per clock while clearing, back to 0 on regclr
   always_ff @(posedge clock) begin
      if (reset || regclr_rise) begin
         clear_addr <= '0;
      end else if (state == ST_CLEAR) begin
         clear_addr <= clear_addr + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Serial shift register, latch/load and counters
   // ---------------------------------------------------------------------
   logic [WORD_BITS-1:0] sr;
   logic [4:0]           bit_count;
   logic                 latched_valid;
   logic                 load_ok;

   // A load only lands when a properly framed word is waiting and the sweep is idle
   assign load_ok = pclk_rise & sin_s & latched_valid & ~clearing & ~regclr_rise;

   // Shift on sclk rise, present MSB on sclk fall, latch/load on pclk rise
   always_ff @(posedge clock) begin
      if (reset) begin
         sr                       <= '0;
         bit_count                <= '0;
         latched_word             <= '0;
         latched_valid            <= 1'b0;
         shout                    <= 1'b0;
         number_of_loads          <= '0;
         number_of_framing_errors <= '0;
      end else begin
         if (sclk_fall) begin
            shout <= sr[WORD_BITS-1];
         end
         if (regclr_rise) begin
            sr            <= '0;
            bit_count     <= '0;
            latched_word  <= '0;
            latched_valid <= 1'b0;
         end else begin
            if (sclk_rise) begin
               sr <= {sr[WORD_BITS-2:0], sin_s};
               if (bit_count != MAX_COUNT) begin
                  bit_count <= bit_count + 5'd1;
               end
            end
            if (pclk_rise) begin
               bit_count <= '0;
               if (!sin_s) begin
                  // sr itself is left intact so the word can be shifted back out
                  latched_word  <= sr;
                  latched_valid <= (bit_count == FULL_COUNT);
                  if (bit_count != FULL_COUNT) begin
                     number_of_framing_errors <= number_of_framing_errors + 32'd1;
                  end
               end else begin
                  latched_valid <= 1'b0;
                  if (load_ok) begin
                     number_of_loads <= number_of_loads + 32'd1;
                  end else begin
                     number_of_framing_errors <= number_of_framing_errors + 32'd1;
                  end
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Register file
   // ---------------------------------------------------------------------
   logic [NUMBER_OF_DATA_BITS-1:0] regfile [DEPTH];

   // Single write port shared by the clear sweep and master loads (never both)
   always_ff @(posedge clock) begin
      if (clearing) begin
         regfile[clear_addr] <= '0;
      end else if (load_ok) begin
         regfile[latched_word[WORD_BITS-1:NUMBER_OF_DATA_BITS]] <= latched_word[NUMBER_OF_DATA_BITS-1:0];
      end
   end

   // Registered host read; a same-cycle write is seen one clock later
   always_ff @(posedge clock) begin
      if (reset) begin
         host_data <= '0;
      end else begin
         host_data <= regfile[host_address];
      end
   end

endmodule
